// File: rtl/mandel_pkg.sv
// Shared constants and state type for the Mandelbrot escape-iteration engine.
package mandel_pkg;

  localparam int unsigned ENGINE_DATA_WIDTH = 25;
  localparam int unsigned FRAC_BITS         = 21;
  localparam int unsigned ITER_W            = 16;
  localparam int unsigned PIX_W             = 20;

  // 4.0 in unsigned Q4.21, sized to hold the un-truncated zr2+zi2 sum
  localparam logic [ENGINE_DATA_WIDTH:0] ESCAPE_THRESH =
    (ENGINE_DATA_WIDTH + 1)'(4 << FRAC_BITS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } esc_state_e;

endpackage

// File: rtl/escape_compare.sv
// Combinational |z|^2 escape test: flags zr2 + zi2 strictly above 4.0.
module escape_compare #(
  parameter int unsigned W = mandel_pkg::ENGINE_DATA_WIDTH
) (
  input  logic [W-1:0] zr2,
  input  logic [W-1:0] zi2,
  output logic         escape_c
);
  import mandel_pkg::*;

  logic [W:0] sum;

  // One extra bit keeps the full sum; the threshold is exclusive.
  assign sum      = {1'b0, zr2} + {1'b0, zi2};
  assign escape_c = (sum > (W + 1)'(ESCAPE_THRESH));

endmodule

// File: rtl/escape_counter.sv
// Per-pixel iteration counter: counts engine samples until escape or the
// iteration limit, then holds the result until the consumer accepts it.
module escape_counter #(
  parameter int unsigned ENGINE_DATA_WIDTH = mandel_pkg::ENGINE_DATA_WIDTH,
  parameter int unsigned ITER_W            = mandel_pkg::ITER_W,
  parameter int unsigned PIX_W             = mandel_pkg::PIX_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [PIX_W-1:0]             pixel_id,
  input  logic [ITER_W-1:0]            max_iter,
  input  logic                         sq_valid,
  input  logic [ENGINE_DATA_WIDTH-1:0] zr2,
  input  logic [ENGINE_DATA_WIDTH-1:0] zi2,
  output logic                         eng_en,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [ITER_W-1:0]            res_iter,
  output logic                         res_escaped,
  output logic [PIX_W-1:0]             res_pixel_id,
  output logic                         busy
);
  import mandel_pkg::*;

  esc_state_e          state_q, state_d;
  logic [ITER_W-1:0]   count_q, count_d;
  logic [ITER_W-1:0]   max_q, max_d;
  logic [ITER_W-1:0]   iter_d;
  logic                esc_d;
  logic [PIX_W-1:0]    pix_d;
  logic [ITER_W:0]     count_inc;
  logic                escape_c;

  escape_compare #(
    .W (ENGINE_DATA_WIDTH)
  ) u_cmp (
    .zr2      (zr2),
    .zi2      (zi2),
    .escape_c (escape_c)
  );

  // count stays below max_q while running, so the widened increment never wraps
  assign count_inc = {1'b0, count_q} + (ITER_W + 1)'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    max_d   = max_q;
    iter_d  = res_iter;
    esc_d   = res_escaped;
    pix_d   = res_pixel_id;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pix_d   = pixel_id;
          max_d   = max_iter;
          count_d = '0;
          if (max_iter == '0) begin
            iter_d  = '0;
            esc_d   = 1'b0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (sq_valid) begin
          if (escape_c) begin
            iter_d  = count_q;
            esc_d   = 1'b1;
            state_d = ST_DONE;
          end else if (count_inc == {1'b0, max_q}) begin
            iter_d  = max_q;
            esc_d   = 1'b0;
            state_d = ST_DONE;
          end else begin
            count_d = count_inc[ITER_W-1:0];
          end
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      max_q        <= '0;
      res_iter     <= '0;
      res_escaped  <= 1'b0;
      res_pixel_id <= '0;
      eng_en       <= 1'b0;
      res_valid    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      max_q        <= max_d;
      res_iter     <= iter_d;
      res_escaped  <= esc_d;
      res_pixel_id <= pix_d;
      eng_en       <= (state_d == ST_RUN);
      res_valid    <= (state_d == ST_DONE);
      busy         <= (state_d != ST_IDLE);
    end
  end

endmodule
